// File: rtl/dither_result_streamer_pkg.sv
// Shared types for the dithering pipeline: control states, result-streamer states and widths.
package dither_result_streamer_pkg;

  localparam int PIX_W  = 8;
  localparam int CSUM_W = 16;

  typedef enum logic [2:0] {
    S0_IDLE,
    S1_LOAD,
    S2_DITHER,
    S3_WRITE,
    S4_CC1
  } state_t;

  typedef enum logic [1:0] {
    SS_IDLE,
    SS_STREAM,
    SS_DONE
  } stream_state_t;

endpackage

// File: rtl/dither_result_streamer_if.sv
// Byte link towards the MCU: the streamer offers tx_data/data_valid, the MCU answers mcu_rx_ready.
interface dither_result_streamer_if
  import dither_result_streamer_pkg::*;
#(
  parameter int DW = PIX_W
) ();

  logic [DW-1:0] tx_data;
  logic          data_valid;
  logic          mcu_rx_ready;

  modport master (output tx_data, output data_valid, input  mcu_rx_ready);
  modport slave  (input  tx_data, input  data_valid, output mcu_rx_ready);

endinterface

// File: rtl/dither_result_streamer_prefetch_buf.sv
// Two-entry synchronous FIFO; head visible combinationally, push/pop same cycle leaves count unchanged.
// No internal overflow/underflow guard: the caller's credit logic keeps push and pop legal.
module stream_prefetch_buf
  import dither_result_streamer_pkg::*;
#(
  parameter int W = PIX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_vld) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push_vld} - {1'b0, pop_vld};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/dither_result_streamer.sv
// Streams the dithered frame from pixel SRAM to the MCU link, one byte per accepted transfer; first byte 3 cycles after start.
// Backpressure: a 2-entry prefetch buffer absorbs the 1-cycle SRAM latency; reads stop while buffer plus in-flight reaches 2.
module dither_result_streamer
  import dither_result_streamer_pkg::*;
#(
  parameter int IMAGEX           = 4,
  parameter int IMAGEY           = 4,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = PIX_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        sram_rd,
  output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
  input  logic [RGB_SIZE-1:0]         sram_rdata,
  dither_result_streamer_if.master    tx,
  output logic                        busy,
  output logic                        done,
  output logic [CSUM_W-1:0]           frame_checksum
);

  localparam int AW = IMAGE_ADDR_WIDTH;
  localparam logic [AW:0] FRAME_LEN = IMAGE_SIZE[AW:0];
  localparam logic [AW:0] ONE       = 1;

  stream_state_t       state_q, state_d;
  logic [AW:0]         rd_addr_q, rd_addr_d;
  logic [AW:0]         sent_q, sent_d;
  logic [CSUM_W-1:0]   csum_q, csum_d;
  logic                inflight_q, inflight_d;

  logic [RGB_SIZE-1:0] buf_head;
  logic [1:0]          buf_count;
  logic                buf_nonempty;
  logic                xfer;
  logic                issue;

  stream_prefetch_buf #(.W(RGB_SIZE)) u_prefetch_buf (
    .clk      (clk),
    .rst      (reset),
    .push_vld (inflight_q),
    .push_dat (sram_rdata),
    .pop_vld  (xfer),
    .head_dat (buf_head),
    .count    (buf_count)
  );

  assign buf_nonempty = (buf_count != 2'd0);
  assign xfer         = (state_q == SS_STREAM) && buf_nonempty && tx.mcu_rx_ready;

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    sent_d     = sent_q;
    csum_d     = csum_q;
    inflight_d = 1'b0;
    issue      = 1'b0;
    case (state_q)
      SS_IDLE: begin
        if (start) begin
          state_d   = SS_STREAM;
          rd_addr_d = '0;
          sent_d    = '0;
          csum_d    = '0;
        end
      end
      SS_STREAM: begin
        // A pop this cycle frees a slot, which is what keeps ready-high streaming at one byte per cycle.
        issue = (rd_addr_q < FRAME_LEN) &&
                ((({1'b0, inflight_q} + buf_count) < 2'd2) || xfer);
        if (issue) begin
          rd_addr_d = rd_addr_q + ONE;
        end
        inflight_d = issue;
        if (xfer) begin
          sent_d = sent_q + ONE;
          csum_d = csum_q + CSUM_W'(buf_head);
          if ((sent_q + ONE) == FRAME_LEN) begin
            state_d = SS_DONE;
          end
        end
      end
      SS_DONE: begin
        state_d = SS_IDLE;
      end
      default: begin
        state_d = SS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SS_IDLE;
      rd_addr_q  <= '0;
      sent_q     <= '0;
      csum_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      sent_q     <= sent_d;
      csum_q     <= csum_d;
      inflight_q <= inflight_d;
    end
  end

  // rd_addr wraps to 0 in the low bits once the frame is fully read, so sram_addr stays in range.
  assign sram_rd        = issue;
  assign sram_addr      = rd_addr_q[AW-1:0];
  assign tx.tx_data     = buf_head;
  assign tx.data_valid  = (state_q == SS_STREAM) && buf_nonempty;
  assign busy           = (state_q == SS_STREAM);
  assign done           = (state_q == SS_DONE);
  assign frame_checksum = csum_q;

endmodule
